unified_buffer_write_control_unit: RTL and testbench
====================================================

# unified_buffer_write_control_unit

Write-side controller of the unified buffer: accepts result rows (post-accumulator/activation) over a valid/ready handshake and writes them into the unified buffer in tile order. Produces the exact address pattern the read controller consumes: output tile `tile_x` occupies `V_dim` consecutive words starting at `base + tile_x*V_dim`. Sits between the activation stage and the unified buffer write port. Signals `done_o` when the whole output matrix is stored.

## Interface
- `DATA_W`, default 256: width of one result row (32 lanes x 8 bit).
- `ADDR_W`, default 12: unified buffer address width.
- `TILE_DIM`, default 32: columns per output tile; a power of two.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: reset; asynchronous, active-high.
- `start_i` in 1: start a write job; sampled in IDLE only.
- `unified_buffer_start_addr_wr_i` in ADDR_W: base address of the job.
- `V_dim1_i` in 7: rows per tile minus 1.
- `W_dim1_i` in 7: output columns minus 1. Tile count is `(W_dim1_i>>5)+1`.
- `result_valid_i` in 1: a result row is present.
- `result_data_i` in DATA_W: the result row.
- `result_ready_o` out 1: the row is accepted when `valid & ready` are both high.
- `unified_buffer_write_en_o` out 1: unified buffer write strobe.
- `unified_buffer_addr_wr_o` out ADDR_W: write address.
- `unified_buffer_data_wr_o` out DATA_W: write data.
- `busy_o` out 1: a job is in progress.
- `done_o` out 1: one-cycle pulse at job completion.

## Operation
- States:
  - IDLE: `result_ready_o=0`. When `start_i=1`, latch base, `V_dim1`, and `last_tile = W_dim1_i>>5`; clear `row` and `tile_x`; set `tile_base = base`; go to WRITE.
  - WRITE: `result_ready_o=1`. Each accept does the following:
    - Register addr = `tile_base + row` and the data.
    - Assert the write strobe on the next cycle.
    - If `row == V_dim1`: clear `row`, increment `tile_x`, and set `tile_base += V_dim1+1` (8-bit add, zero-extended). Otherwise increment `row`.
    - If the accept is the last one (`row==V_dim1 & tile_x==last_tile`): go to DONE.
  - DONE: lasts one cycle, then go to IDLE.
- `result_ready_o` is a combinational decode of the state (WRITE only). It has no dependence on `result_valid_i`.
- Address arithmetic is modulo 2^ADDR_W; a carry out of the top bit wraps.
- `start_i` outside IDLE is ignored.
- `result_valid_i` outside WRITE is not accepted. Data is held by the producer.
- Total words written per job: `(last_tile+1)*(V_dim1+1)`. The minimum job is 1 word (`V_dim1=0`, `W_dim1<32`).

## Timing
- Reset values: `unified_buffer_write_en_o=0`, `unified_buffer_addr_wr_o=0`, `unified_buffer_data_wr_o=0`, `result_ready_o=0`, `busy_o=0`, `done_o=0`. State is IDLE. All counters are 0.
- Start latency: `start_i` high at edge N gives `result_ready_o=1` from cycle N+1.
- Write latency: an accept at edge K gives `write_en/addr/data` valid during cycle K+1. This is exactly 1 cycle, with one strobe per accept. No strobe occurs in cycles without an accept.
- Last accept at edge K:
  - During cycle K+1 the state is DONE, `done_o=1`, and the final write strobe is high.
  - At K+2 the state is IDLE and `busy_o=0`.
- `busy_o` is high in WRITE and DONE.
- Back-to-back jobs: `start_i` held high in the DONE cycle is ignored. It is taken on the first IDLE cycle.
- Asserting `rst_i` mid-job immediately (asynchronously) clears all outputs and returns to IDLE. A write pending in the output register is dropped.

## Configuration
- `UB_WR_ERR_EN` defined: adds output `error_o` (1 bit, reset 0), which is sticky and cleared only by reset or an accepted `start_i`.
  - It is set by the first address wrap (carry out of `tile_base + row`) and by `start_i` asserted while not IDLE.
  - After a wrap, the handshake continues (rows are accepted and counted) but `unified_buffer_write_en_o` is forced to 0 for the rest of the job.
  - `done_o` still pulses.
- `UB_WR_ERR_EN` undefined: no `error_o` port. Wrapped addresses are written normally.

## Test plan
- Single tile: base=0x100, `V_dim1=3`, `W_dim1=31`, valid held high. Expected: writes at 0x100..0x103 on 4 consecutive cycles; `done_o` coincides with the 0x103 write; `busy_o` falls the next cycle.
- Two tiles: base=0x010, `V_dim1=2`, `W_dim1=63`. Expected: addresses 0x010..0x015 in order, with data matching the accept order.
- Backpressure: valid pattern 1,0,0,1,1,0,1 with `V_dim1=3`. Expected: exactly 4 strobes, each 1 cycle after its accept, and no strobe in gap cycles.
- Wrap: base=0xFFE, `V_dim1=3`.
  - Without the macro: 0xFFE, 0xFFF, 0x000, 0x001.
  - With `UB_WR_ERR_EN`: 0xFFE and 0xFFF are written; `error_o=1` from the wrap; the remaining 2 rows are accepted and not written; `done_o` pulses.
- Reset mid-job after 2 of 4 accepts: all outputs 0 immediately. A new start at base 0x200 then writes from 0x200.
- `start_i` pulsed during WRITE: ignored, with addresses unaffected; with `UB_WR_ERR_EN`, `error_o=1`.

Source files
------------

// File: rtl/unified_buffer_write_control_unit.sv
// -----------------------------------------------------------------------------
// unified_buffer_write_control_unit
//
// Write-side controller of the unified buffer. It accepts result rows from the
// activation stage and stores them in tile order. Output tile tile_x occupies
// (V_dim1+1) consecutive words starting at base + tile_x*(V_dim1+1), which is
// the pattern the read controller walks. done_o pulses once the whole output
// matrix has been stored.
//
// Handshake: a result row transfers on a rising clk_i edge where
// result_valid_i and result_ready_o are both high. result_ready_o depends only
// on the FSM state (high in WRITE) and never on result_valid_i. The producer
// holds result_data_i stable until the row has been accepted.
//
// Optional feature (macro UB_WR_ERR_EN):
//   When defined, an error_o output is added. It is sticky and is cleared only
//   by reset or by an accepted start_i. It is set by the first address wrap
//   (carry out of tile_base + row) or by start_i asserted outside IDLE. After
//   a wrap the job continues to accept rows, but no further writes are issued.
//   When undefined, wrapped addresses are written normally.
//
// Ports:
//   clk_i                          clock
//   rst_i                          asynchronous active-high reset
//   start_i                        start a job (sampled in IDLE only)
//   unified_buffer_start_addr_wr_i base address of the job
//   V_dim1_i                       rows per tile minus 1
//   W_dim1_i                       output columns minus 1
//   result_valid_i / result_ready_o / result_data_i   input row handshake
//   unified_buffer_write_en_o      write strobe (1 cycle after each accept)
//   unified_buffer_addr_wr_o       write address
//   unified_buffer_data_wr_o       write data
//   busy_o                         job in progress (WRITE or DONE)
//   done_o                         one-cycle pulse at job completion
//   error_o                        sticky error (UB_WR_ERR_EN only)
//   state_dbg_o                    current FSM state (0 IDLE, 1 WRITE, 2 DONE)
// -----------------------------------------------------------------------------
module unified_buffer_write_control_unit #(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 12,
    parameter int TILE_DIM = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] unified_buffer_start_addr_wr_i,
    input  logic [6:0]        V_dim1_i,
    input  logic [6:0]        W_dim1_i,
    input  logic              result_valid_i,
    input  logic [DATA_W-1:0] result_data_i,
    output logic              result_ready_o,
    output logic              unified_buffer_write_en_o,
    output logic [ADDR_W-1:0] unified_buffer_addr_wr_o,
    output logic [DATA_W-1:0] unified_buffer_data_wr_o,
    output logic              busy_o,
    output logic              done_o,
`ifdef UB_WR_ERR_EN
    output logic              error_o,
`endif
    output logic [1:0]        state_dbg_o
);

    localparam int TILE_SHIFT = $clog2(TILE_DIM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] tile_base;
    logic [6:0]        v_dim1;
    logic [6:0]        last_tile;
    logic [6:0]        row;
    logic [6:0]        tile_x;

    logic              accept;
    logic              last_accept;
    logic              start_take;
    logic [7:0]        tile_step;
    logic [ADDR_W-1:0] addr_next;

    assign accept      = result_valid_i & (state == S_WRITE);
    assign last_accept = accept & (row == v_dim1) & (tile_x == last_tile);
    assign start_take  = (state == S_IDLE) & start_i;
    // Tile stride is V_dim1+1 computed on 8 bits so V_dim1=127 gives 128.
    assign tile_step   = {1'b0, v_dim1} + 8'd1;
    assign state_dbg_o = state;

`ifdef UB_WR_ERR_EN
    logic addr_carry;
    logic wrapped;
    assign {addr_carry, addr_next} = {1'b0, tile_base} + (ADDR_W+1)'(row);
`else
    // Modulo 2^ADDR_W: the carry simply falls off the top.
    assign addr_next = tile_base + ADDR_W'(row);
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        result_ready_o = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                result_ready_o = 1'b1;
                busy_o         = 1'b1;
                if (last_accept) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy_o     = 1'b1;
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Job counters and registered write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tile_base                 <= '0;
            v_dim1                    <= '0;
            last_tile                 <= '0;
            row                       <= '0;
            tile_x                    <= '0;
            unified_buffer_write_en_o <= 1'b0;
            unified_buffer_addr_wr_o  <= '0;
            unified_buffer_data_wr_o  <= '0;
`ifdef UB_WR_ERR_EN
            wrapped                   <= 1'b0;
`endif
        end else begin
            // The strobe is high only in the cycle right after an accept.
            unified_buffer_write_en_o <= 1'b0;
            if (start_take) begin
                tile_base <= unified_buffer_start_addr_wr_i;
                v_dim1    <= V_dim1_i;
                last_tile <= W_dim1_i >> TILE_SHIFT;
                row       <= '0;
                tile_x    <= '0;
`ifdef UB_WR_ERR_EN
                wrapped   <= 1'b0;
`endif
            end else if (accept) begin
                unified_buffer_addr_wr_o <= addr_next;
                unified_buffer_data_wr_o <= result_data_i;
`ifdef UB_WR_ERR_EN
                // The wrapping row itself and every later row of the job
                // are accepted but not written.
                unified_buffer_write_en_o <= ~(wrapped | addr_carry);
                if (addr_carry) begin
                    wrapped <= 1'b1;
                end
`else
                unified_buffer_write_en_o <= 1'b1;
`endif
                if (row == v_dim1) begin
                    row       <= '0;
                    tile_x    <= tile_x + 7'd1;
                    tile_base <= tile_base + ADDR_W'(tile_step);
                end else begin
                    row <= row + 7'd1;
                end
            end
        end
    end

`ifdef UB_WR_ERR_EN
    // -------------------------------------------------------------------------
    // Sticky error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_o <= 1'b0;
        end else if (start_take) begin
            error_o <= 1'b0;
        end else if ((start_i && (state != S_IDLE)) || (accept && addr_carry)) begin
            error_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_unified_buffer_write_control_unit.sv
// -----------------------------------------------------------------------------
// Testbench for unified_buffer_write_control_unit.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// either at that point or at the falling edge. A monitor on the falling edge
// sees which rows will be accepted at the next rising edge, computes the
// expected write (address = base + accept index, modulo 2^12) and pushes it to
// exp_q; the following falling edge checks the strobe and pops the entry.
// -----------------------------------------------------------------------------
module tb_unified_buffer_write_control_unit;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_in;
    logic [6:0]        v_in;
    logic [6:0]        w_in;
    logic              result_valid;
    logic [DATA_W-1:0] result_data;
    logic              result_ready;
    logic              ub_we;
    logic [ADDR_W-1:0] ub_addr;
    logic [DATA_W-1:0] ub_data;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;
`ifdef UB_WR_ERR_EN
    logic              error;
`endif

    unified_buffer_write_control_unit #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .TILE_DIM (32)
    ) dut (
        .clk_i                          (clk),
        .rst_i                          (rst),
        .start_i                        (start),
        .unified_buffer_start_addr_wr_i (base_in),
        .V_dim1_i                       (v_in),
        .W_dim1_i                       (w_in),
        .result_valid_i                 (result_valid),
        .result_data_i                  (result_data),
        .result_ready_o                 (result_ready),
        .unified_buffer_write_en_o      (ub_we),
        .unified_buffer_addr_wr_o       (ub_addr),
        .unified_buffer_data_wr_o       (ub_data),
        .busy_o                         (busy),
        .done_o                         (done),
`ifdef UB_WR_ERR_EN
        .error_o                        (error),
`endif
        .state_dbg_o                    (state_dbg)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ scoreboard
    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_word;
    bit                       mon_en = 1'b0;
    bit                       pend_strobe = 1'b0;
    int                       m_base = 0;
    int                       m_k = 0;
    int                       m_left = 0;
    bit                       m_wrapped = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (ub_we !== pend_strobe) begin
                bad++;
                $display("FAIL strobe t=%0t got=%b exp=%b", $time, ub_we, pend_strobe);
            end else if (ub_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL write_unexpected t=%0t addr=%h", $time, ub_addr);
                end else begin
                    exp_word = exp_q.pop_front();
                    total++;
                    if ({ub_addr, ub_data} !== exp_word) begin
                        bad++;
                        $display("FAIL write t=%0t got addr=%h data=%h exp addr=%h data=%h",
                                 $time, ub_addr, ub_data,
                                 exp_word[ADDR_W+DATA_W-1:DATA_W], exp_word[DATA_W-1:0]);
                    end
                end
            end
            if (ub_we === 1'b1) strobe_cnt++;
            pend_strobe = 1'b0;
            if (result_valid === 1'b1 && result_ready === 1'b1) begin
                total++;
                if (m_left == 0) begin
                    bad++;
                    $display("FAIL extra_accept t=%0t got accept exp none", $time);
                end else begin
                    if (m_base + m_k >= (1 << ADDR_W)) m_wrapped = 1'b1;
`ifdef UB_WR_ERR_EN
                    if (!m_wrapped) begin
`else
                    begin
`endif
                        exp_q.push_back({ADDR_W'(m_base + m_k), result_data});
                        pend_strobe = 1'b1;
                    end
                    m_k++;
                    m_left--;
                end
            end
        end
    end

    // ---------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_row();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic start_job(input logic [ADDR_W-1:0] base, input logic [6:0] v,
                             input logic [6:0] w);
        total++;
        if (result_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_idle got=%b exp=0", result_ready);
        end
        base_in = base;
        v_in    = v;
        w_in    = w;
        start   = 1'b1;
        m_base    = int'(base);
        m_k       = 0;
        m_left    = ((int'(w) >> 5) + 1) * (int'(v) + 1);
        m_wrapped = 1'b0;
        tick();
        start = 1'b0;
        total++;
        if (result_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_start got=%b exp=1", result_ready);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start got=%b exp=1", busy);
        end
        total++;
        if (state_dbg !== 2'd1) begin
            bad++;
            $display("FAIL state_write got=%0d exp=1", state_dbg);
        end
`ifdef UB_WR_ERR_EN
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL error_cleared got=%b exp=0", error);
        end
`endif
    endtask

    // mode 0: valid held high, 1: pattern 1,0,0,1,1,0,1, 2: random valid,
    // 3: valid high with a start pulse (other base) on the second cycle.
    task automatic stream(input int mode);
        int  cyc = 0;
        logic [6:0] pat = 7'b1011001;
        while (m_left != 0 && cyc < 300) begin
            case (mode)
                1:       result_valid = (cyc < 7) ? pat[cyc] : 1'b1;
                2:       result_valid = 1'($urandom_range(0, 1));
                default: result_valid = 1'b1;
            endcase
            if (mode == 3) begin
                start   = (cyc == 1);
                base_in = 12'h500;
            end
            result_data = rand_row();
            tick();
            cyc++;
        end
        start        = 1'b0;
        result_valid = 1'b0;
        total++;
        if (m_left != 0) begin
            bad++;
            $display("FAIL stream_timeout rows_left=%0d exp=0", m_left);
        end
    endtask

    // Called in the cycle after the last accept (the DONE cycle).
    task automatic finish_job(input logic [ADDR_W-1:0] last_addr, input bit last_we);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse got=%b exp=1", done);
        end
        total++;
        if (state_dbg !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_state got state=%0d busy=%b exp state=2 busy=1", state_dbg, busy);
        end
        total++;
        if (ub_we !== last_we) begin
            bad++;
            $display("FAIL last_strobe got=%b exp=%b", ub_we, last_we);
        end
        if (last_we) begin
            total++;
            if (ub_addr !== last_addr) begin
                bad++;
                $display("FAIL last_addr got=%h exp=%h", ub_addr, last_addr);
            end
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result_ready !== 1'b0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL after_done got busy=%b done=%b ready=%b state=%0d exp 0 0 0 0",
                     busy, done, result_ready, state_dbg);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL writes_missing got=%0d pending exp=0", exp_q.size());
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if (ub_we !== 1'b0 || ub_addr !== '0 || ub_data !== '0 || result_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL %s got we=%b addr=%h ready=%b busy=%b done=%b state=%0d exp all 0",
                     tag, ub_we, ub_addr, result_ready, busy, done, state_dbg);
        end
        total++;
        if (ub_data !== '0) begin
            bad++;
            $display("FAIL %s_data got=%h exp=0", tag, ub_data);
        end
`ifdef UB_WR_ERR_EN
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL %s_error got=%b exp=0", tag, error);
        end
`endif
    endtask

    // ------------------------------------------------------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset_idle");
        mon_en = 1'b1;
    endtask

    task automatic test_single_tile();
        start_job(12'h100, 7'd3, 7'd31);
        stream(0);
        finish_job(12'h103, 1'b1);
    endtask

    task automatic test_two_tiles();
        start_job(12'h010, 7'd2, 7'd63);
        stream(0);
        finish_job(12'h015, 1'b1);
    endtask

    task automatic test_backpressure();
        strobe_cnt = 0;
        start_job(12'h040, 7'd3, 7'd0);
        stream(1);
        finish_job(12'h043, 1'b1);
        total++;
        if (strobe_cnt != 4) begin
            bad++;
            $display("FAIL backpressure_strobes got=%0d exp=4", strobe_cnt);
        end
    endtask

    task automatic test_random_valid();
        start_job(12'h7F0, 7'd4, 7'd95);
        stream(2);
        finish_job(12'h7FE, 1'b1);
    endtask

    task automatic test_wrap();
        strobe_cnt = 0;
        start_job(12'hFFE, 7'd3, 7'd5);
        stream(0);
`ifdef UB_WR_ERR_EN
        finish_job(12'h001, 1'b0);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL wrap_error got=%b exp=1", error);
        end
        total++;
        if (strobe_cnt != 2) begin
            bad++;
            $display("FAIL wrap_strobes got=%0d exp=2", strobe_cnt);
        end
`else
        finish_job(12'h001, 1'b1);
        total++;
        if (strobe_cnt != 4) begin
            bad++;
            $display("FAIL wrap_strobes got=%0d exp=4", strobe_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_job();
        start_job(12'h300, 7'd3, 7'd0);
        result_valid = 1'b1;
        result_data  = rand_row();
        tick();
        result_data  = rand_row();
        tick();
        total++;
        if (ub_we !== 1'b1) begin
            bad++;
            $display("FAIL pending_write got=%b exp=1", ub_we);
        end
        result_valid = 1'b0;
        mon_en       = 1'b0;
        rst          = 1'b1;
        #1;
        check_all_zero("mid_job_reset");
        exp_q.delete();
        pend_strobe = 1'b0;
        m_left      = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_all_zero("mid_job_reset_idle");
        mon_en = 1'b1;
        start_job(12'h200, 7'd1, 7'd0);
        stream(0);
        finish_job(12'h201, 1'b1);
    endtask

    task automatic test_start_during_write();
        start_job(12'h080, 7'd3, 7'd0);
        stream(3);
`ifdef UB_WR_ERR_EN
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL start_in_write_error got=%b exp=1", error);
        end
`endif
        finish_job(12'h083, 1'b1);
    endtask

    task automatic test_back_to_back();
        start_job(12'h020, 7'd1, 7'd0);
        stream(0);
        // DONE cycle: hold start high with a new job's parameters.
        base_in = 12'h600;
        v_in    = 7'd0;
        w_in    = 7'd0;
        start   = 1'b1;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done got=%b exp=1", done);
        end
        tick();
        total++;
        if (state_dbg !== 2'd0 || result_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got state=%0d ready=%b busy=%b exp 0 0 0",
                     state_dbg, result_ready, busy);
        end
        m_base    = 12'h600;
        m_k       = 0;
        m_left    = 1;
        m_wrapped = 1'b0;
        tick();
        start = 1'b0;
        total++;
        if (result_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_start got ready=%b exp=1", result_ready);
        end
        stream(0);
        finish_job(12'h600, 1'b1);
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        base_in      = '0;
        v_in         = '0;
        w_in         = '0;
        result_valid = 1'b0;
        result_data  = '0;
        test_reset();
        test_single_tile();
        test_two_tiles();
        test_backpressure();
        test_random_valid();
        test_wrap();
        test_reset_mid_job();
        test_start_during_write();
        test_back_to_back();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
